// File: rtl/proc_datapath.sv
// Register-file / ALU datapath for the simple processor: shared bus, R0..R7,
// operand register A, result register G, and the zero/carry/bus_err flags.
module proc_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    // "extern" is a reserved word in SystemVerilog, so the strobe is extern_sel.
    input  logic             extern_sel,
    input  logic [7:0]       R_out,
    input  logic             G_out,
    input  logic [7:0]       R_in,
    input  logic             A_in,
    input  logic             G_in,
    input  logic [3:0]       func,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] dbg_q,
    output logic             zero,
    output logic             carry,
    output logic             bus_err
);

    localparam logic [3:0] FUNC_ADD = 4'b0010;
    localparam logic [3:0] FUNC_SUB = 4'b0011;
    localparam logic [3:0] FUNC_NOT = 4'b0100;
    localparam logic [3:0] FUNC_AND = 4'b0101;
    localparam logic [3:0] FUNC_OR  = 4'b0110;
    localparam logic [3:0] FUNC_XOR = 4'b0111;

    logic [WIDTH-1:0] regs_r [8];
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] g_r;
    logic             zero_r;
    logic             carry_r;
    logic             bus_err_r;

    logic [9:0]       drivers_s;
    logic             multi_drv_s;
    logic [WIDTH-1:0] wired_or_s;
    logic [WIDTH-1:0] bus_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_cout_s;
    logic             alu_sets_carry_s;

    // Returns {carry, result}; carry is carry-out for add and no-borrow for sub.
    function automatic logic [WIDTH:0] alu_f(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        sum  = {1'b0, a} + {1'b0, y};
        diff = {1'b0, a} - {1'b0, y};
        case (op)
            FUNC_ADD: alu_f = sum;
            FUNC_SUB: alu_f = {~diff[WIDTH], diff[WIDTH-1:0]};
            FUNC_NOT: alu_f = {1'b0, ~y};
            FUNC_AND: alu_f = {1'b0, a & y};
            FUNC_OR:  alu_f = {1'b0, a | y};
            FUNC_XOR: alu_f = {1'b0, a ^ y};
            default:  alu_f = {1'b0, y};
        endcase
    endfunction

    // Driver census: more than one set bit means a bus conflict.
    always_comb begin
        drivers_s   = {extern_sel, G_out, R_out};
        multi_drv_s = ((drivers_s & (drivers_s - 10'd1)) != 10'd0);
    end

    // OR of every enabled source; exact for zero or one driver.
    always_comb begin
        wired_or_s = {WIDTH{1'b0}};
        if (extern_sel) begin
            wired_or_s = wired_or_s | data_in;
        end else begin
            wired_or_s = wired_or_s;
        end
        if (G_out) begin
            wired_or_s = wired_or_s | g_r;
        end else begin
            wired_or_s = wired_or_s;
        end
        for (int i = 0; i < 8; i++) begin
            if (R_out[i]) begin
                wired_or_s = wired_or_s | regs_r[i];
            end else begin
                wired_or_s = wired_or_s;
            end
        end
    end

    // Conflicting drivers force the bus to zero.
    always_comb begin
        bus_s = {WIDTH{1'b0}};
        if (multi_drv_s) begin
            bus_s = {WIDTH{1'b0}};
        end else begin
            bus_s = wired_or_s;
        end
    end

    // ALU on the pre-edge A and the current bus.
    always_comb begin
        {alu_cout_s, alu_res_s} = alu_f(func, a_r, bus_s);
        alu_sets_carry_s        = (func == FUNC_ADD) || (func == FUNC_SUB);
    end

    // General register file loads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (R_in[i]) begin
                    regs_r[i] <= bus_s;
                end
            end
        end
    end

    // Operand register A.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_r <= {WIDTH{1'b0}};
        end else if (A_in) begin
            a_r <= bus_s;
        end
    end

    // Result register G with its zero/carry flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            g_r     <= {WIDTH{1'b0}};
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
        end else if (G_in) begin
            g_r    <= alu_res_s;
            zero_r <= (alu_res_s == {WIDTH{1'b0}});
            if (alu_sets_carry_s) begin
                carry_r <= alu_cout_s;
            end
        end
    end

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err_r <= 1'b0;
        end else if (multi_drv_s) begin
            bus_err_r <= 1'b1;
        end
    end

    assign bus_out = bus_s;
    assign dbg_q   = regs_r[dbg_sel];
    assign zero    = zero_r;
    assign carry   = carry_r;
    assign bus_err = bus_err_r;

endmodule

// File: tb/tb_proc_datapath.sv
// Directed self-checking bench for proc_datapath with hand-computed vectors.
module tb_proc_datapath;

    logic        clk;
    logic        resetn;
    logic [15:0] data_in;
    logic        extern_sel;
    logic [7:0]  R_out;
    logic        G_out;
    logic [7:0]  R_in;
    logic        A_in;
    logic        G_in;
    logic [3:0]  func;
    logic [2:0]  dbg_sel;
    logic [15:0] bus_out;
    logic [15:0] dbg_q;
    logic        zero;
    logic        carry;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    proc_datapath #(.WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .data_in(data_in), .extern_sel(extern_sel),
        .R_out(R_out), .G_out(G_out), .R_in(R_in), .A_in(A_in), .G_in(G_in),
        .func(func), .dbg_sel(dbg_sel), .bus_out(bus_out), .dbg_q(dbg_q),
        .zero(zero), .carry(carry), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        data_in = 16'h0000; extern_sel = 1'b0; R_out = 8'h00; G_out = 1'b0;
        R_in = 8'h00; A_in = 1'b0; G_in = 1'b0; func = 4'h0;
    endtask

    // One controller step: inputs already set, take the edge, return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_ext(input logic [7:0] dst, input logic [15:0] val);
        extern_sel = 1'b1; data_in = val; R_in = dst;
        tick();
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [7:0] src);
        R_out = src; G_in = 1'b1; func = op;
        tick();
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, dbg_q, exp);
    endtask

    task automatic check_g(input string tag, input logic [15:0] exp);
        G_out = 1'b1;
        #1;
        check(tag, bus_out, exp);
        G_out = 1'b0;
    endtask

    initial begin
        idle();
        dbg_sel = 3'd0;
        resetn  = 1'b0;
        #12;
        resetn = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a transfer.
        load_ext(8'h01, 16'h1111);
        check_reg("r0_preload", 3'd0, 16'h1111);
        extern_sel = 1'b1; data_in = 16'hBEEF; R_in = 8'h01;
        #1;
        resetn = 1'b0;
        #1;
        check_reg("r0_async_clr", 3'd0, 16'h0000);
        check("bus_in_reset", bus_out, 16'hBEEF);
        @(posedge clk);
        #1;
        check_reg("r0_no_load_in_reset", 3'd0, 16'h0000);
        check("bus_err_reset", {15'd0, bus_err}, 16'h0000);
        check("zero_reset", {15'd0, zero}, 16'h0000);
        check("carry_reset", {15'd0, carry}, 16'h0000);
        idle();
        @(negedge clk);
        resetn = 1'b1;
        #1;

        // Load and move.
        load_ext(8'h08, 16'h1234);
        check_reg("r3_load", 3'd3, 16'h1234);
        R_out = 8'h08; R_in = 8'h20;
        tick();
        check_reg("r5_move", 3'd5, 16'h1234);
        check_reg("r3_kept", 3'd3, 16'h1234);

        // Add with wrap.
        load_ext(8'h01, 16'hFFFF);
        load_ext(8'h02, 16'h0001);
        R_out = 8'h01; A_in = 1'b1;
        tick();
        alu_op(4'b0010, 8'h02);
        G_out = 1'b1; R_in = 8'h01;
        tick();
        check_reg("add_r0", 3'd0, 16'h0000);
        check("add_zero", {15'd0, zero}, 16'h0001);
        check("add_carry", {15'd0, carry}, 16'h0001);

        // Subtract then xor with A = 5.
        load_ext(8'h04, 16'h0005);
        load_ext(8'h10, 16'h0007);
        load_ext(8'h40, 16'h00FF);
        load_ext(8'h80, 16'h0F0F);
        R_out = 8'h04; A_in = 1'b1;
        tick();
        alu_op(4'b0011, 8'h10);
        check_g("sub_g", 16'hFFFE);
        check("sub_carry", {15'd0, carry}, 16'h0000);
        check("sub_zero", {15'd0, zero}, 16'h0000);
        alu_op(4'b0111, 8'h40);
        check_g("xor_g", 16'h00FA);
        check("xor_carry_hold", {15'd0, carry}, 16'h0000);
        check("xor_zero", {15'd0, zero}, 16'h0000);

        // Unary NOT.
        alu_op(4'b0100, 8'h80);
        check_g("not_g", 16'hF0F0);

        // A_in with G_in: ALU sees old A (5), A takes bus (G = F0F0).
        G_out = 1'b1; A_in = 1'b1; G_in = 1'b1; func = 4'b0010;
        tick();
        check_g("old_a_add", 16'hF0F5);
        check("old_a_carry", {15'd0, carry}, 16'h0000);

        // G_out with G_in: G = A + G_old = F0F0 + F0F5.
        G_out = 1'b1; G_in = 1'b1; func = 4'b0010;
        tick();
        check_g("g_loop_add", 16'hE1E5);
        check("g_loop_carry", {15'd0, carry}, 16'h0001);

        alu_op(4'b0101, 8'h40);
        check_g("and_g", 16'h00F0);
        check("and_carry_hold", {15'd0, carry}, 16'h0001);
        alu_op(4'b1111, 8'h40);
        check_g("pass_f_g", 16'h00FF);
        alu_op(4'b0000, 8'h00);
        check_g("pass_empty_bus", 16'h0000);
        check("pass_zero", {15'd0, zero}, 16'h0001);
        check("pass_carry_hold", {15'd0, carry}, 16'h0001);

        // Bus conflict.
        check("bus_err_clean", {15'd0, bus_err}, 16'h0000);
        R_out = 8'h03; R_in = 8'h80;
        #1;
        check("conflict_bus", bus_out, 16'h0000);
        tick();
        check_reg("conflict_r7", 3'd7, 16'h0000);
        check("conflict_err", {15'd0, bus_err}, 16'h0001);
        load_ext(8'h01, 16'h00AA);
        tick();
        check("err_sticky", {15'd0, bus_err}, 16'h0001);
        check_reg("post_conflict_load", 3'd0, 16'h00AA);
        resetn = 1'b0;
        #1;
        check("err_reset_clr", {15'd0, bus_err}, 16'h0000);
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
